complex_int_wb_arbiter: RTL and testbench

Shares the single register-write slot of one complex-integer lane between the fixed-latency multiplier pipe and the iterative divider. Multiplier results have priority. Divider results are parked in a small FIFO and drain into idle slots. An optional starvation guard asks the scheduler for a multiplier bubble. The block sits between the complex-integer execution stage and the complex-integer register-write stage, and drives that stage's pipeline register input.

---
 rtl/complex_int_wb_arbiter_pkg.sv | 31 +++
 rtl/complex_wb_div_fifo.sv | 95 +++++++++
 rtl/complex_int_wb_arbiter.sv | 143 ++++++++++++++
 tb/tb_complex_int_wb_arbiter.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/complex_int_wb_arbiter_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ComplexWbArbiterTypes: grant encoding and flush-range helper shared by the
// complex-integer writeback arbiter.                              Rev 1.0
// ----------------------------------------------------------------------------
package ComplexWbArbiterTypes;

    // Widest active-list pointer the flush helper accepts; callers zero-extend.
    localparam int AL_PTR_MAX = 16;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_MUL  = 2'd1,
        GNT_DIV  = 2'd2
    } grant_t;

    // Half-open [head, tail) on the pointer ring; head == tail is empty.
    // Written as a two-case compare so zero-extension keeps the ring semantics.
    function automatic logic InFlushRange(
        input logic [AL_PTR_MAX-1:0] ptr,
        input logic [AL_PTR_MAX-1:0] head,
        input logic [AL_PTR_MAX-1:0] tail
    );
        if (head <= tail) begin
            return (ptr >= head) && (ptr < tail);
        end
        return (ptr >= head) || (ptr < tail);
    endfunction

endpackage
`default_nettype wire

// File: rtl/complex_wb_div_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// complex_wb_div_fifo: divider result holding FIFO with per-entry flush clear
// and compaction so the head is always a live entry.              Rev 1.0
// ----------------------------------------------------------------------------
module complex_wb_div_fifo
    import ComplexWbArbiterTypes::*;
#(
    parameter int PAYLOAD_WIDTH = 96,
    parameter int AL_PTR_WIDTH  = 7,
    parameter int DEPTH         = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     to_recovery_phase,
    input  logic                     flush_all_insns,
    input  logic [AL_PTR_WIDTH-1:0]  flush_head_ptr,
    input  logic [AL_PTR_WIDTH-1:0]  flush_tail_ptr,
    input  logic                     push,
    input  logic [PAYLOAD_WIDTH-1:0] push_payload,
    input  logic [AL_PTR_WIDTH-1:0]  push_al_ptr,
    input  logic                     pop,
    output logic                     head_valid,
    output logic [PAYLOAD_WIDTH-1:0] head_payload,
    output logic [AL_PTR_WIDTH-1:0]  head_al_ptr,
    output logic                     ready
);

    typedef struct packed {
        logic                     valid;
        logic [PAYLOAD_WIDTH-1:0] payload;
        logic [AL_PTR_WIDTH-1:0]  al_ptr;
    } entry_t;

    entry_t mem      [DEPTH];
    entry_t kept     [DEPTH];
    entry_t mem_next [DEPTH];
    int     kept_count;
    int     after_pop;

    always_comb begin
        for (int j = 0; j < DEPTH; j++) begin
            kept[j]     = '0;
            mem_next[j] = '0;
        end
        kept_count = 0;

        // Survivors of this cycle's flush, packed toward slot 0 in age order.
        for (int i = 0; i < DEPTH; i++) begin
            if (mem[i].valid && !(to_recovery_phase && (flush_all_insns ||
                    InFlushRange(AL_PTR_MAX'(mem[i].al_ptr),
                                 AL_PTR_MAX'(flush_head_ptr),
                                 AL_PTR_MAX'(flush_tail_ptr))))) begin
                for (int j = 0; j < DEPTH; j++) begin
                    if (j == kept_count) begin
                        kept[j] = mem[i];
                    end
                end
                kept_count = kept_count + 1;
            end
        end

        after_pop = kept_count - (pop ? 1 : 0);

        for (int j = 1; j < DEPTH; j++) begin
            mem_next[j-1] = pop ? kept[j] : kept[j-1];
        end
        mem_next[DEPTH-1] = pop ? '0 : kept[DEPTH-1];

        for (int j = 0; j < DEPTH; j++) begin
            if (push && (j == after_pop)) begin
                mem_next[j] = {1'b1, push_payload, push_al_ptr};
            end
        end
    end

    assign head_valid   = kept[0].valid;
    assign head_payload = kept[0].payload;
    assign head_al_ptr  = kept[0].al_ptr;
    assign ready        = (after_pop < DEPTH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 0; j < DEPTH; j++) begin
                mem[j] <= '0;
            end
        end else begin
            for (int j = 0; j < DEPTH; j++) begin
                mem[j] <= mem_next[j];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/complex_int_wb_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// complex_int_wb_arbiter: shares one writeback slot between the multiplier
// (priority) and buffered divider results. Optional starvation guard is built
// when RSD_COMPLEX_WB_STARVE_GUARD_EN is defined.                  Rev 1.0
// ----------------------------------------------------------------------------
module complex_int_wb_arbiter
    import ComplexWbArbiterTypes::*;
#(
    parameter int PAYLOAD_WIDTH = 96,
    parameter int AL_PTR_WIDTH  = 7,
    parameter int DIV_BUF_DEPTH = 2,
    parameter int STARVE_LIMIT  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     stall,
    input  logic                     mulValid,
    input  logic [PAYLOAD_WIDTH-1:0] mulPayload,
    input  logic [AL_PTR_WIDTH-1:0]  mulAlPtr,
    input  logic                     divValid,
    input  logic [PAYLOAD_WIDTH-1:0] divPayload,
    input  logic [AL_PTR_WIDTH-1:0]  divAlPtr,
    output logic                     divReady,
    input  logic                     toRecoveryPhase,
    input  logic                     flushAllInsns,
    input  logic [AL_PTR_WIDTH-1:0]  flushHeadPtr,
    input  logic [AL_PTR_WIDTH-1:0]  flushTailPtr,
    output logic                     wbValid,
    output logic [PAYLOAD_WIDTH-1:0] wbPayload,
    output logic [AL_PTR_WIDTH-1:0]  wbAlPtr,
    output logic                     wbFromDiv,
    output logic                     mulHold
);

    if (DIV_BUF_DEPTH < 1 || (DIV_BUF_DEPTH & (DIV_BUF_DEPTH - 1)) != 0 ||
        STARVE_LIMIT < 1 || AL_PTR_WIDTH > AL_PTR_MAX) begin : g_param_check
        $error("complex_int_wb_arbiter: illegal parameter set");
    end

    logic                     mul_flushed;
    logic                     div_flushed;
    logic                     head_valid;
    logic [PAYLOAD_WIDTH-1:0] head_payload;
    logic [AL_PTR_WIDTH-1:0]  head_al_ptr;
    logic                     fifo_ready;
    logic                     pop;
    logic                     push;
    grant_t                   grant;
    logic [PAYLOAD_WIDTH-1:0] sel_payload;
    logic [AL_PTR_WIDTH-1:0]  sel_al_ptr;

    assign mul_flushed = toRecoveryPhase && (flushAllInsns ||
        InFlushRange(AL_PTR_MAX'(mulAlPtr), AL_PTR_MAX'(flushHeadPtr), AL_PTR_MAX'(flushTailPtr)));
    assign div_flushed = toRecoveryPhase && (flushAllInsns ||
        InFlushRange(AL_PTR_MAX'(divAlPtr), AL_PTR_MAX'(flushHeadPtr), AL_PTR_MAX'(flushTailPtr)));

    always_comb begin
        grant       = GNT_NONE;
        pop         = 1'b0;
        sel_payload = mulPayload;
        sel_al_ptr  = mulAlPtr;
        if (!stall) begin
            if (mulValid && !mul_flushed) begin
                grant = GNT_MUL;
            end else if (head_valid) begin
                grant       = GNT_DIV;
                pop         = 1'b1;
                sel_payload = head_payload;
                sel_al_ptr  = head_al_ptr;
            end else if (divValid && !div_flushed) begin
                // Empty FIFO: the arriving divider result bypasses straight out.
                grant       = GNT_DIV;
                sel_payload = divPayload;
                sel_al_ptr  = divAlPtr;
            end
        end
    end

    assign push     = divValid && !div_flushed && fifo_ready && !(grant == GNT_DIV && !pop);
    assign divReady = fifo_ready;

    complex_wb_div_fifo #(
        .PAYLOAD_WIDTH (PAYLOAD_WIDTH),
        .AL_PTR_WIDTH  (AL_PTR_WIDTH),
        .DEPTH         (DIV_BUF_DEPTH)
    ) u_div_fifo (
        .clk               (clk),
        .rst               (rst),
        .to_recovery_phase (toRecoveryPhase),
        .flush_all_insns   (flushAllInsns),
        .flush_head_ptr    (flushHeadPtr),
        .flush_tail_ptr    (flushTailPtr),
        .push              (push),
        .push_payload      (divPayload),
        .push_al_ptr       (divAlPtr),
        .pop               (pop),
        .head_valid        (head_valid),
        .head_payload      (head_payload),
        .head_al_ptr       (head_al_ptr),
        .ready             (fifo_ready)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wbValid   <= 1'b0;
            wbFromDiv <= 1'b0;
            wbPayload <= '0;
            wbAlPtr   <= '0;
        end else if (!stall) begin
            wbValid   <= (grant != GNT_NONE);
            wbFromDiv <= (grant == GNT_DIV);
            if (grant != GNT_NONE) begin
                wbPayload <= sel_payload;
                wbAlPtr   <= sel_al_ptr;
            end
        end
    end

`ifdef RSD_COMPLEX_WB_STARVE_GUARD_EN
    localparam int WAIT_W = $clog2(STARVE_LIMIT + 1);

    logic [WAIT_W-1:0] wait_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
            mulHold  <= 1'b0;
        end else begin
            if (pop || !head_valid) begin
                wait_cnt <= '0;
            end else if (!stall && grant == GNT_MUL && wait_cnt != WAIT_W'(STARVE_LIMIT)) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            mulHold <= (wait_cnt == WAIT_W'(STARVE_LIMIT));
        end
    end
`else
    assign mulHold = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_complex_int_wb_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_complex_int_wb_arbiter: directed stimulus with a queue-based scoreboard
// for the complex-integer writeback arbiter.                      Rev 1.0
// ----------------------------------------------------------------------------
module tb_complex_int_wb_arbiter;

    localparam int PW = 96;
    localparam int AW = 7;

`ifdef RSD_COMPLEX_WB_STARVE_GUARD_EN
    localparam logic EXP_HOLD = 1'b1;
`else
    localparam logic EXP_HOLD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          stall = 1'b0;
    logic          mulValid = 1'b0;
    logic [PW-1:0] mulPayload = '0;
    logic [AW-1:0] mulAlPtr = '0;
    logic          divValid = 1'b0;
    logic [PW-1:0] divPayload = '0;
    logic [AW-1:0] divAlPtr = '0;
    logic          divReady;
    logic          toRecoveryPhase = 1'b0;
    logic          flushAllInsns = 1'b0;
    logic [AW-1:0] flushHeadPtr = '0;
    logic [AW-1:0] flushTailPtr = '0;
    logic          wbValid;
    logic [PW-1:0] wbPayload;
    logic [AW-1:0] wbAlPtr;
    logic          wbFromDiv;
    logic          mulHold;

    complex_int_wb_arbiter dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .mulValid        (mulValid),
        .mulPayload      (mulPayload),
        .mulAlPtr        (mulAlPtr),
        .divValid        (divValid),
        .divPayload      (divPayload),
        .divAlPtr        (divAlPtr),
        .divReady        (divReady),
        .toRecoveryPhase (toRecoveryPhase),
        .flushAllInsns   (flushAllInsns),
        .flushHeadPtr    (flushHeadPtr),
        .flushTailPtr    (flushTailPtr),
        .wbValid         (wbValid),
        .wbPayload       (wbPayload),
        .wbAlPtr         (wbAlPtr),
        .wbFromDiv       (wbFromDiv),
        .mulHold         (mulHold)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          from_div;
        logic [AW-1:0] ptr;
    } exp_t;

    exp_t exp_q [$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic upd      = 1'b0;

    function automatic logic [PW-1:0] pay(input logic [AW-1:0] p, input logic d);
        return {12{d, p}};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic drive(input logic mv, input logic [AW-1:0] mp, input logic dv, input logic [AW-1:0] dp);
        mulValid   = mv;
        mulAlPtr   = mp;
        mulPayload = pay(mp, 1'b0);
        divValid   = dv;
        divAlPtr   = dp;
        divPayload = pay(dp, 1'b1);
    endtask

    task automatic expect_wb(input logic d, input logic [AW-1:0] p);
        exp_q.push_back('{from_div: d, ptr: p});
    endtask

    // Marks cycles whose posedge actually loaded the writeback register.
    always @(posedge clk) upd <= !stall && !rst;

    always @(negedge clk) begin
        if (upd && wbValid) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL wb_unexpected: got ptr %0d from_div %0b, required no writeback", wbAlPtr, wbFromDiv);
            end else begin
                mon_e = exp_q.pop_front();
                if (wbAlPtr !== mon_e.ptr || wbFromDiv !== mon_e.from_div ||
                    wbPayload !== pay(mon_e.ptr, mon_e.from_div)) begin
                    n_fail++;
                    $display("FAIL wb_entry: got ptr %0d from_div %0b payload %h, required ptr %0d from_div %0b",
                             wbAlPtr, wbFromDiv, wbPayload, mon_e.ptr, mon_e.from_div);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_divReady",  32'(divReady),  32'd1);
        check("rst_wbValid",   32'(wbValid),   32'd0);
        check("rst_wbFromDiv", 32'(wbFromDiv), 32'd0);
        check("rst_wbAlPtr",   32'(wbAlPtr),   32'd0);
        check("rst_wbPayload", 32'(wbPayload == '0), 32'd1);
        check("rst_mulHold",   32'(mulHold),   32'd0);

        // Lone divider result bypasses the empty FIFO
        @(negedge clk); drive(1'b0, 7'd0, 1'b1, 7'd5); expect_wb(1'b1, 7'd5);
        @(negedge clk); drive(1'b0, 7'd0, 1'b0, 7'd0);
        @(negedge clk); #1 check("idle_wbValid", 32'(wbValid), 32'd0);

        // Multiplier every cycle starves one buffered divider result
        for (int i = 0; i < 12; i++) begin
            @(negedge clk); drive(1'b1, 7'd3, (i == 0), 7'd9); expect_wb(1'b0, 7'd3);
        end
        @(negedge clk); #1;
        check("starve_mulHold", 32'(mulHold), 32'(EXP_HOLD));
        drive(1'b0, 7'd0, 1'b0, 7'd0); expect_wb(1'b1, 7'd9);
        repeat (3) @(negedge clk);
        #1 check("drained_mulHold", 32'(mulHold), 32'd0);

        // Fill FIFO with 1 and 2, then flush [2,3)
        @(negedge clk); drive(1'b1, 7'd40, 1'b1, 7'd1); expect_wb(1'b0, 7'd40);
        @(negedge clk); drive(1'b1, 7'd40, 1'b1, 7'd2); expect_wb(1'b0, 7'd40);
        @(negedge clk); drive(1'b1, 7'd40, 1'b0, 7'd0); expect_wb(1'b0, 7'd40);
        #1 check("full_divReady", 32'(divReady), 32'd0);
        @(negedge clk);
        toRecoveryPhase = 1'b1; flushHeadPtr = 7'd2; flushTailPtr = 7'd3;
        drive(1'b1, 7'd40, 1'b0, 7'd0); expect_wb(1'b0, 7'd40);
        #1 check("flushed_divReady", 32'(divReady), 32'd1);
        @(negedge clk); toRecoveryPhase = 1'b0;
        drive(1'b0, 7'd0, 1'b0, 7'd0); expect_wb(1'b1, 7'd1);
        repeat (3) @(negedge clk);

        // Wrap-around flush [126,1): 127 and 0 die, 1 and 125 survive
        @(negedge clk); drive(1'b1, 7'd100, 1'b1, 7'd127); expect_wb(1'b0, 7'd100);
        @(negedge clk); drive(1'b1, 7'd100, 1'b1, 7'd0);   expect_wb(1'b0, 7'd100);
        @(negedge clk);
        toRecoveryPhase = 1'b1; flushHeadPtr = 7'd126; flushTailPtr = 7'd1;
        drive(1'b1, 7'd125, 1'b1, 7'd1); expect_wb(1'b0, 7'd125);
        #1 check("wrap_divReady", 32'(divReady), 32'd1);
        @(negedge clk); drive(1'b1, 7'd127, 1'b0, 7'd0); expect_wb(1'b1, 7'd1);
        @(negedge clk); flushAllInsns = 1'b1; drive(1'b1, 7'd33, 1'b0, 7'd0);
        @(negedge clk); toRecoveryPhase = 1'b0; flushAllInsns = 1'b0;
        drive(1'b0, 7'd0, 1'b0, 7'd0);
        #1 check("flushall_wbValid", 32'(wbValid), 32'd0);
        repeat (2) @(negedge clk);

        // Stall freezes outputs; push still accepted; no pop until release
        @(negedge clk); drive(1'b1, 7'd50, 1'b0, 7'd0); expect_wb(1'b0, 7'd50);
        @(negedge clk); stall = 1'b1; drive(1'b1, 7'd60, 1'b1, 7'd7);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) begin
                @(negedge clk); drive(1'b1, 7'd60, 1'b0, 7'd0);
            end
            #1;
            check("stall_wbAlPtr",   32'(wbAlPtr),   32'd50);
            check("stall_wbFromDiv", 32'(wbFromDiv), 32'd0);
        end
        check("stall_divReady", 32'(divReady), 32'd1);
        @(negedge clk); stall = 1'b0; drive(1'b0, 7'd0, 1'b0, 7'd0); expect_wb(1'b1, 7'd7);
        repeat (3) @(negedge clk);

        // Asynchronous reset with two buffered entries
        @(negedge clk); drive(1'b1, 7'd20, 1'b1, 7'd11); expect_wb(1'b0, 7'd20);
        @(negedge clk); drive(1'b1, 7'd20, 1'b1, 7'd12); expect_wb(1'b0, 7'd20);
        @(negedge clk); drive(1'b0, 7'd0, 1'b0, 7'd0);
        #3 rst = 1'b1;
        #1;
        check("async_rst_divReady", 32'(divReady), 32'd1);
        check("async_rst_wbValid",  32'(wbValid),  32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        check("post_rst_wbValid", 32'(wbValid), 32'd0);
        check("pending_expected", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
